brownout_dig_mc: RTL and testbench
==================================

Name: brownout_dig_mc

Overview:
Parametrised multi-channel successor to the brown-out digital controller. It serves NCH analog supply-monitor channels; each channel has its own comparator input and trip-code selection.
- Per channel: synchronises the raw comparator output, debounces it and asserts a brown-out flag.
- After the supply recovers, it holds that flag for a programmable one-shot period.
- Shared across channels: the RC-oscillator enable, and registered one-hot trip-code decoding for the analog resistor-string muxes.

Parameters:
NCH, 2, number of monitored supply channels (1..8)
TRIP_W, 3, trip-code width per channel; decoded width is 2**TRIP_W
FILT_CYC, 4, consecutive synchronised-high cycles required to trip (>=1)
HOLD_LONG, 1024, one-shot hold length in osc_ck cycles (>=2)
HOLD_SHORT, 8, hold length when force_short_oneshot=1 (>=2, <=HOLD_LONG)

Ports:
osc_ck  input  1  RC-oscillator clock; the only clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable
trip  input  NCH*TRIP_W  per-channel trip codes, channel i at [i*TRIP_W +: TRIP_W]
chan_mask  input  NCH  1 = channel i ignored
dcomp  input  NCH  raw asynchronous comparator outputs, 1 = supply below threshold
force_ena_rc_osc  input  1  force oscillator on
force_dis_rc_osc  input  1  force oscillator off
force_short_oneshot  input  1  select HOLD_SHORT
trip_decoded  output  NCH*2**TRIP_W  registered one-hot decode per channel
out_unbuf  output  NCH  per-channel brown-out flag
out_any  output  1  registered OR of out_unbuf
brout_filt  output  NCH  1 while channel i is in TRIP
timed_out  output  NCH  one-cycle pulse at hold expiry
osc_ena  output  1  RC-oscillator enable (combinational)

Behaviour:
- Reset (rst_n=0, asynchronous): all channels IDLE, synchronisers 0, counters 0. Outputs trip_decoded, out_unbuf, out_any, brout_filt and timed_out are all 0.
- ena=0 (synchronous): on the next edge, all channels go to IDLE, synchronisers clear and trip_decoded=0. Registered outputs read 0 from then on.
- Trip decode, per channel: trip_decoded bit trip[i] set one edge after trip changes. The decode does not depend on chan_mask.
- Synchroniser, per channel: 2 flops on dcomp[i] & ~chan_mask[i]; its output is dcomp_s[i].
- Channel FSM, states IDLE/FILT/TRIP/HOLD; counter width clog2(max(FILT_CYC,HOLD_LONG)):
  - IDLE: dcomp_s=1 -> FILT, cnt=0.
  - FILT: dcomp_s=0 -> IDLE. Else if cnt==FILT_CYC-1 -> TRIP. Else cnt+1.
  - TRIP: dcomp_s=0 -> HOLD, cnt=(force_short_oneshot ? HOLD_SHORT : HOLD_LONG)-1. Hold length is sampled only at this entry.
  - HOLD: dcomp_s=1 -> TRIP, abandoning the hold. Else if cnt==0 -> IDLE and timed_out[i]=1 for exactly one cycle. Else cnt-1.
- Per-channel outputs: out_unbuf[i]=1 in TRIP or HOLD, registered from state. brout_filt[i]=1 in TRIP only.
- Latency:
  - dcomp stable high before edge k: out_unbuf high after edge k+2+FILT_CYC.
  - dcomp low before edge m, with no re-trip: out_unbuf low after edge m+2+HOLD_len.
- Glitch rejection: a synchronised pulse shorter than FILT_CYC cycles causes no trip.
- Masking mid-operation: setting chan_mask[i] while in TRIP drives dcomp_s low after 2 edges. The channel then runs a normal hold; it is not cleared.
- out_any: registered OR of out_unbuf, one cycle after out_unbuf.
- osc_ena = force_ena_rc_osc | (~force_dis_rc_osc & ena & (|(dcomp & ~chan_mask) | any synchroniser bit high | any channel not IDLE)).
  - force_ena has priority over force_dis.
  - osc_ena is glitch-free relative to its inputs, and stays high until the FSM returns to IDLE.
- Simultaneous events: channels are fully independent. Several timed_out pulses may coincide.

Decomposition:
- Package brownout_pkg:
  - bod_state_t enum (IDLE, FILT, TRIP, HOLD)
  - function onehot_decode(code, width)
  - localparam helper for counter width
- Sub-module bod_chan: one channel, containing synchroniser, FSM, counter, out_unbuf/brout_filt/timed_out and trip decode.
- The top generates NCH instances and adds the out_any register and osc_ena logic.

Test Plan:
- Reset/decode: rst_n low then high, ena=1, trip[2:0]=3'd5 -> trip_decoded[7:0]=8'b0010_0000 one edge later. All flags 0.
- Trip latency: FILT_CYC=4, dcomp[0] rises before edge k -> out_unbuf[0]=1 after edge k+6, out_any after k+7, brout_filt[0]=1. Channel 1 remains 0.
- Glitch: dcomp[1] high for 3 cycles -> FILT entered then IDLE. out_unbuf[1] never asserts.
- Hold and short one-shot:
  - force_short_oneshot=1, dcomp[0] falls before edge m -> out_unbuf[0] low after edge m+10 (HOLD_SHORT=8).
  - timed_out[0] pulses high for exactly one cycle.
  - dcomp re-rising at m+5 -> back to TRIP, no timed_out pulse.
- Oscillator control:
  - force_dis_rc_osc=1 -> osc_ena=0 despite dcomp=1.
  - Adding force_ena_rc_osc=1 -> osc_ena=1.
  - With no forces, osc_ena stays high through HOLD and falls once IDLE is reached.
- ena/mask mid-operation:
  - ena drops during HOLD -> all outputs 0 after next edge, no timed_out pulse.
  - chan_mask[1]=1 while dcomp[1]=1 -> channel 1 never trips.

Source files
------------

// File: rtl/brownout_dig_mc_pkg.sv
// Shared types and helpers for the multi-channel brown-out controller.
package brownout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILT = 2'd1,
    TRIP = 2'd2,
    HOLD = 2'd3
  } bod_state_t;

  localparam int MAX_CODE_W = 8;
  localparam int MAX_DEC_W  = 2 ** MAX_CODE_W;

  // Width of a down/up counter able to hold max(a,b)-1, never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

  function automatic logic [MAX_DEC_W-1:0] onehot_decode(input logic [MAX_CODE_W-1:0] code,
                                                         input int unsigned width);
    logic [MAX_DEC_W-1:0] res;
    res = '0;
    if (int'(code) < int'(width)) res[code] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/brownout_dig_mc_if.sv
// Control/status bundle between the brown-out controller and its environment.
interface brownout_dig_mc_if #(
  parameter int NCH    = 2,
  parameter int TRIP_W = 3
);
  localparam int DEC_W = 2 ** TRIP_W;

  logic                    ena;
  logic [NCH*TRIP_W-1:0]   trip;
  logic [NCH-1:0]          chan_mask;
  logic [NCH-1:0]          dcomp;
  logic                    force_ena_rc_osc;
  logic                    force_dis_rc_osc;
  logic                    force_short_oneshot;
  logic [NCH*DEC_W-1:0]    trip_decoded;
  logic [NCH-1:0]          out_unbuf;
  logic                    out_any;
  logic [NCH-1:0]          brout_filt;
  logic [NCH-1:0]          timed_out;
  logic                    osc_ena;

  modport master (
    output ena, trip, chan_mask, dcomp,
    output force_ena_rc_osc, force_dis_rc_osc, force_short_oneshot,
    input  trip_decoded, out_unbuf, out_any, brout_filt, timed_out, osc_ena
  );

  modport slave (
    input  ena, trip, chan_mask, dcomp,
    input  force_ena_rc_osc, force_dis_rc_osc, force_short_oneshot,
    output trip_decoded, out_unbuf, out_any, brout_filt, timed_out, osc_ena
  );
endinterface

// File: rtl/brownout_dig_mc_chan.sv
// One supply-monitor channel: synchroniser, debounce/hold FSM and trip-code decode.
module bod_chan
  import brownout_pkg::*;
#(
  parameter int TRIP_W     = 3,
  parameter int FILT_CYC   = 4,
  parameter int HOLD_LONG  = 1024,
  parameter int HOLD_SHORT = 8
) (
  input  logic                   osc_ck,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   force_short_oneshot,
  input  logic [TRIP_W-1:0]      trip,
  input  logic                   mask,
  input  logic                   dcomp,
  output logic [2**TRIP_W-1:0]   trip_decoded,
  output logic                   out_unbuf,
  output logic                   brout_filt,
  output logic                   timed_out,
  output logic                   sync_any,
  output logic                   busy
);
  localparam int DEC_W = 2 ** TRIP_W;
  localparam int CNT_W = cnt_width(FILT_CYC, HOLD_LONG);
  localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LLAST = CNT_W'(HOLD_LONG - 1);
  localparam logic [CNT_W-1:0] HOLD_SLAST = CNT_W'(HOLD_SHORT - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             dcomp_s;
  bod_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [MAX_DEC_W-1:0] dec_full;

  assign dcomp_s  = sync_p1;
  assign sync_any = sync_p0 | sync_p1;
  assign busy     = (state != IDLE);
  assign dec_full = onehot_decode(MAX_CODE_W'(trip), DEC_W);

  // Two-flop synchroniser; masking is applied before the first flop.
  always_ff @(posedge osc_ck or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else if (!ena) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= dcomp & ~mask;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge osc_ck or negedge rst_n) begin
    if (!rst_n) begin
      trip_decoded <= '0;
    end else if (!ena) begin
      trip_decoded <= '0;
    end else begin
      trip_decoded <= dec_full[DEC_W-1:0];
    end
  end

  // Outputs are assigned on the same edge as the state change so they track state without extra delay.
  always_ff @(posedge osc_ck or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out_unbuf  <= 1'b0;
      brout_filt <= 1'b0;
      timed_out  <= 1'b0;
    end else if (!ena) begin
      state      <= IDLE;
      cnt        <= '0;
      out_unbuf  <= 1'b0;
      brout_filt <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      timed_out <= 1'b0;
      case (state)
        IDLE: begin
          if (dcomp_s) begin
            state <= FILT;
            cnt   <= '0;
          end
        end
        FILT: begin
          if (!dcomp_s) begin
            state <= IDLE;
          end else if (cnt == FILT_LAST) begin
            state      <= TRIP;
            out_unbuf  <= 1'b1;
            brout_filt <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRIP: begin
          // Hold length is latched here only; later changes of the select do not affect a running hold.
          if (!dcomp_s) begin
            state      <= HOLD;
            brout_filt <= 1'b0;
            cnt        <= force_short_oneshot ? HOLD_SLAST : HOLD_LLAST;
          end
        end
        HOLD: begin
          if (dcomp_s) begin
            state      <= TRIP;
            brout_filt <= 1'b1;
          end else if (cnt == '0) begin
            state     <= IDLE;
            out_unbuf <= 1'b0;
            timed_out <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          out_unbuf  <= 1'b0;
          brout_filt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/brownout_dig_mc.sv
// Multi-channel brown-out controller: NCH independent channels plus shared oscillator enable.
module brownout_dig_mc
  import brownout_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int TRIP_W     = 3,
  parameter int FILT_CYC   = 4,
  parameter int HOLD_LONG  = 1024,
  parameter int HOLD_SHORT = 8
) (
  input  logic        osc_ck,
  input  logic        rst_n,
  brownout_dig_mc_if.slave bod
);
  localparam int DEC_W = 2 ** TRIP_W;

  logic [NCH*DEC_W-1:0] trip_dec_w;
  logic [NCH-1:0]       out_unbuf_w;
  logic [NCH-1:0]       brout_filt_w;
  logic [NCH-1:0]       timed_out_w;
  logic [NCH-1:0]       sync_any_w;
  logic [NCH-1:0]       busy_w;
  logic                 out_any_r;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    bod_chan #(
      .TRIP_W    (TRIP_W),
      .FILT_CYC  (FILT_CYC),
      .HOLD_LONG (HOLD_LONG),
      .HOLD_SHORT(HOLD_SHORT)
    ) u_chan (
      .osc_ck              (osc_ck),
      .rst_n               (rst_n),
      .ena                 (bod.ena),
      .force_short_oneshot (bod.force_short_oneshot),
      .trip                (bod.trip[i*TRIP_W +: TRIP_W]),
      .mask                (bod.chan_mask[i]),
      .dcomp               (bod.dcomp[i]),
      .trip_decoded        (trip_dec_w[i*DEC_W +: DEC_W]),
      .out_unbuf           (out_unbuf_w[i]),
      .brout_filt          (brout_filt_w[i]),
      .timed_out           (timed_out_w[i]),
      .sync_any            (sync_any_w[i]),
      .busy                (busy_w[i])
    );
  end

  always_ff @(posedge osc_ck or negedge rst_n) begin
    if (!rst_n) begin
      out_any_r <= 1'b0;
    end else if (!bod.ena) begin
      out_any_r <= 1'b0;
    end else begin
      out_any_r <= |out_unbuf_w;
    end
  end

  // Oscillator stays on while any raw request, synchroniser bit or active channel exists; force-on wins.
  assign bod.osc_ena = bod.force_ena_rc_osc |
                       (~bod.force_dis_rc_osc & bod.ena &
                        ((|(bod.dcomp & ~bod.chan_mask)) | (|sync_any_w) | (|busy_w)));

  assign bod.trip_decoded = trip_dec_w;
  assign bod.out_unbuf    = out_unbuf_w;
  assign bod.brout_filt   = brout_filt_w;
  assign bod.timed_out    = timed_out_w;
  assign bod.out_any      = out_any_r;

endmodule

// File: tb/tb_brownout_dig_mc.sv
// Directed bench for brownout_dig_mc (NCH=2, TRIP_W=3, FILT_CYC=4, HOLD_LONG=1024, HOLD_SHORT=8).
module tb_brownout_dig_mc;
  logic osc_ck = 1'b0;
  logic rst_n  = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic seen;

  brownout_dig_mc_if #(.NCH(2), .TRIP_W(3)) bod ();

  brownout_dig_mc #(
    .NCH(2), .TRIP_W(3), .FILT_CYC(4), .HOLD_LONG(1024), .HOLD_SHORT(8)
  ) dut (
    .osc_ck (osc_ck),
    .rst_n  (rst_n),
    .bod    (bod.slave)
  );

  always #5 osc_ck = ~osc_ck;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge osc_ck);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bod.ena = 1'b0;
    bod.trip = '0;
    bod.chan_mask = '0;
    bod.dcomp = '0;
    bod.force_ena_rc_osc = 1'b0;
    bod.force_dis_rc_osc = 1'b0;
    bod.force_short_oneshot = 1'b0;
    tick(2);
    chk("rst_trip_dec", 32'(bod.trip_decoded), 32'h0);
    chk("rst_out_unbuf", 32'(bod.out_unbuf), 32'h0);
    chk("rst_out_any", 32'(bod.out_any), 32'h0);
    chk("rst_brout_filt", 32'(bod.brout_filt), 32'h0);
    chk("rst_timed_out", 32'(bod.timed_out), 32'h0);
    chk("rst_osc_ena", 32'(bod.osc_ena), 32'h0);

    // Decode: ch0=5, ch1=2
    rst_n = 1'b1;
    bod.ena = 1'b1;
    bod.trip = {3'd2, 3'd5};
    tick(1);
    chk("dec_5_2", 32'(bod.trip_decoded), 32'h0420);
    chk("dec_flags", 32'(bod.out_unbuf), 32'h0);
    bod.trip = {3'd7, 3'd0};
    tick(1);
    chk("dec_0_7", 32'(bod.trip_decoded), 32'h8001);
    bod.trip = {3'd2, 3'd5};
    tick(1);

    // Trip latency on ch0
    bod.dcomp = 2'b01;
    #1 chk("osc_raw_req", 32'(bod.osc_ena), 32'h1);
    tick(6);
    chk("trip_pre_k5", 32'(bod.out_unbuf), 32'h0);
    tick(1);
    chk("trip_k6_unbuf", 32'(bod.out_unbuf), 32'h1);
    chk("trip_k6_filt", 32'(bod.brout_filt), 32'h1);
    chk("trip_k6_any", 32'(bod.out_any), 32'h0);
    tick(1);
    chk("trip_k7_any", 32'(bod.out_any), 32'h1);

    // Glitch on ch1: 3 cycles high
    bod.dcomp = 2'b11;
    tick(3);
    bod.dcomp = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen = seen | bod.out_unbuf[1] | bod.brout_filt[1];
    end
    chk("glitch_ch1", 32'(seen), 32'h0);
    chk("glitch_ch0_kept", 32'(bod.out_unbuf), 32'h1);

    // Short hold on ch0
    bod.force_short_oneshot = 1'b1;
    bod.dcomp = 2'b00;
    tick(3);
    chk("hold_filt_low", 32'(bod.brout_filt), 32'h0);
    tick(7);
    chk("hold_m9_unbuf", 32'(bod.out_unbuf), 32'h1);
    chk("hold_m9_to", 32'(bod.timed_out), 32'h0);
    chk("hold_m9_osc", 32'(bod.osc_ena), 32'h1);
    tick(1);
    chk("hold_m10_unbuf", 32'(bod.out_unbuf), 32'h0);
    chk("hold_m10_to", 32'(bod.timed_out), 32'h1);
    chk("hold_m10_osc", 32'(bod.osc_ena), 32'h0);
    chk("hold_m10_any", 32'(bod.out_any), 32'h1);
    tick(1);
    chk("hold_m11_to", 32'(bod.timed_out), 32'h0);
    chk("hold_m11_any", 32'(bod.out_any), 32'h0);

    // Re-trip during hold
    bod.dcomp = 2'b01;
    tick(7);
    chk("retrip_trip", 32'(bod.brout_filt), 32'h1);
    bod.dcomp = 2'b00;
    tick(5);
    bod.dcomp = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen = seen | (|bod.timed_out);
    end
    chk("retrip_no_to", 32'(seen), 32'h0);
    chk("retrip_back", 32'(bod.brout_filt), 32'h1);

    // Oscillator forces
    bod.force_dis_rc_osc = 1'b1;
    #1 chk("osc_force_dis", 32'(bod.osc_ena), 32'h0);
    bod.force_ena_rc_osc = 1'b1;
    #1 chk("osc_force_both", 32'(bod.osc_ena), 32'h1);
    bod.force_dis_rc_osc = 1'b0;
    bod.force_ena_rc_osc = 1'b0;

    // ena drop during hold
    bod.dcomp = 2'b00;
    tick(4);
    chk("enadrop_in_hold", 32'(bod.out_unbuf), 32'h1);
    chk("enadrop_filt", 32'(bod.brout_filt), 32'h0);
    bod.ena = 1'b0;
    tick(1);
    chk("enadrop_unbuf", 32'(bod.out_unbuf), 32'h0);
    chk("enadrop_dec", 32'(bod.trip_decoded), 32'h0);
    chk("enadrop_any", 32'(bod.out_any), 32'h0);
    chk("enadrop_osc", 32'(bod.osc_ena), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | (|bod.timed_out);
    end
    chk("enadrop_no_to", 32'(seen), 32'h0);

    // Masked channel 1
    bod.ena = 1'b1;
    tick(1);
    chk("reena_dec", 32'(bod.trip_decoded), 32'h0420);
    bod.chan_mask = 2'b10;
    bod.dcomp = 2'b10;
    #1 chk("mask_osc", 32'(bod.osc_ena), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen = seen | bod.out_unbuf[1];
    end
    chk("mask_no_trip", 32'(seen), 32'h0);
    bod.chan_mask = 2'b00;
    bod.dcomp = 2'b00;
    tick(3);

    // Long hold on ch0
    bod.force_short_oneshot = 1'b0;
    bod.dcomp = 2'b01;
    tick(7);
    chk("long_trip", 32'(bod.out_unbuf), 32'h1);
    bod.dcomp = 2'b00;
    tick(1026);
    chk("long_m1025", 32'(bod.out_unbuf), 32'h1);
    tick(1);
    chk("long_m1026_unbuf", 32'(bod.out_unbuf), 32'h0);
    chk("long_m1026_to", 32'(bod.timed_out), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
